// File: rtl/memshare_wraddr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : memshare_wraddr_ctrl
// Brief    : memShare write-back address generator with DRC1 rebasing.
// Revision : 1.0
// ============================================================================
module memshare_wraddr_ctrl #(
    parameter int          ADDR_WIDTH    = 5,
    parameter int          LEN_WIDTH     = 5,
    parameter int          DRC_NUM       = 3,
    parameter int unsigned ADDR_BASE     = 0,
    parameter int unsigned REBASE_STRIDE = 8
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  scu_begin_i,
    input  logic [LEN_WIDTH-1:0]  wb_len_i,
    input  logic                  wr_valid_i,
    input  logic [DRC_NUM-1:0]    is_drc_i,
    input  logic                  stall_i,
    output logic                  wr_ready_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [ADDR_WIDTH-1:0] drc_base_addr_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [ADDR_WIDTH-1:0] c_addr_base = ADDR_WIDTH'(ADDR_BASE);
    localparam logic [ADDR_WIDTH-1:0] c_stride    = ADDR_WIDTH'(REBASE_STRIDE);
    localparam logic [DRC_NUM-1:0]    c_drc1_only = DRC_NUM'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [ADDR_WIDTH-1:0] r_drc_base;
    logic [LEN_WIDTH-1:0]  r_remain;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;

    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_cur_nxt;
    logic [ADDR_WIDTH-1:0] w_base_nxt;
    logic [LEN_WIDTH-1:0]  w_remain_nxt;
    logic                  w_wr_en_nxt;
    logic [ADDR_WIDTH-1:0] w_wr_addr_nxt;
    logic                  w_accept;
    logic                  w_rebase;
    logic [ADDR_WIDTH-1:0] w_beat_addr;

    assign wr_ready_o      = (r_state == S_WRITE) && !stall_i;
    // A restart request wins over a beat presented in the same cycle.
    assign w_accept        = wr_ready_o && wr_valid_i && !scu_begin_i;
    assign w_rebase        = (is_drc_i == c_drc1_only);
    assign w_beat_addr     = w_rebase ? (r_drc_base + c_stride) : r_cur_addr;

    assign wr_en_o         = r_wr_en;
    assign wr_addr_o       = r_wr_addr;
    assign drc_base_addr_o = r_drc_base;
    assign busy_o          = (r_state == S_WRITE);
    assign done_o          = (r_state == S_DONE);

    always_comb begin
        w_state_nxt   = r_state;
        w_cur_nxt     = r_cur_addr;
        w_base_nxt    = r_drc_base;
        w_remain_nxt  = r_remain;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;

        if (scu_begin_i) begin
            w_cur_nxt    = c_addr_base;
            w_base_nxt   = c_addr_base;
            w_remain_nxt = wb_len_i;
            w_state_nxt  = (wb_len_i == '0) ? S_DONE : S_WRITE;
        end else begin
            case (r_state)
                S_WRITE: begin
                    if (w_accept) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = w_beat_addr;
                        w_cur_nxt     = w_beat_addr + ADDR_WIDTH'(1);
                        if (w_rebase) begin
                            w_base_nxt = w_beat_addr;
                        end
                        w_remain_nxt = r_remain - LEN_WIDTH'(1);
                        if (r_remain == LEN_WIDTH'(1)) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cur_addr <= c_addr_base;
            r_drc_base <= c_addr_base;
            r_remain   <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= c_addr_base;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_addr <= w_cur_nxt;
            r_drc_base <= w_base_nxt;
            r_remain   <= w_remain_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memshare_wraddr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_memshare_wraddr_ctrl
// Brief    : Vector table, corner sequences and random run against a model.
// Revision : 1.0
// ============================================================================
module tb_memshare_wraddr_ctrl;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       scu_begin;
    logic [4:0] wb_len;
    logic       wr_valid;
    logic [2:0] is_drc;
    logic       stall;

    logic       rdy0, en0, busy0, done0;
    logic [4:0] addr0, base0;
    logic       rdy1, en1, busy1, done1;
    logic [4:0] addr1, base1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    memshare_wraddr_ctrl u_dut0 (
        .sys_clk(sys_clk), .rst(rst), .scu_begin_i(scu_begin), .wb_len_i(wb_len),
        .wr_valid_i(wr_valid), .is_drc_i(is_drc), .stall_i(stall),
        .wr_ready_o(rdy0), .wr_en_o(en0), .wr_addr_o(addr0),
        .drc_base_addr_o(base0), .busy_o(busy0), .done_o(done0)
    );

    memshare_wraddr_ctrl #(.ADDR_BASE(30)) u_dut1 (
        .sys_clk(sys_clk), .rst(rst), .scu_begin_i(scu_begin), .wb_len_i(wb_len),
        .wr_valid_i(wr_valid), .is_drc_i(is_drc), .stall_i(stall),
        .wr_ready_o(rdy1), .wr_en_o(en1), .wr_addr_o(addr1),
        .drc_base_addr_o(base1), .busy_o(busy1), .done_o(done1)
    );

    // Row: inputs for one cycle, then outputs expected during that cycle.
    typedef struct packed {
        logic       beg;
        logic [4:0] len;
        logic       vld;
        logic [2:0] drc;
        logic       stl;
        logic       en;
        logic [4:0] addr;
        logic [4:0] base;
        logic       busy;
        logic       done;
        logic       rdy;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic b, input logic [4:0] l, input logic v,
                         input logic [2:0] d, input logic s);
        @(negedge sys_clk);
        scu_begin = b;
        wb_len    = l;
        wr_valid  = v;
        is_drc    = d;
        stall     = s;
        #1;
    endtask

    function automatic int pack0();
        return int'({en0, addr0, base0, busy0, done0, rdy0});
    endfunction

    function automatic int pack1();
        return int'({en1, addr1, base1, busy1, done1, rdy1});
    endfunction

    // Behavioural model: phase 0 idle, 1 writing, 2 period finished.
    int m_ph[2], m_rem[2], m_cur[2], m_base[2], m_wa[2];
    bit m_we[2];
    int m_org[2] = '{0, 30};

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0; m_rem[i] = 0; m_cur[i] = m_org[i];
            m_base[i] = m_org[i]; m_wa[i] = m_org[i]; m_we[i] = 0;
        end
    endtask

    function automatic int model_exp(input int i);
        logic rdy;
        rdy = (m_ph[i] == 1) && !stall;
        return int'({m_we[i] ? 1'b1 : 1'b0, 5'(m_wa[i]), 5'(m_base[i]),
                     (m_ph[i] == 1) ? 1'b1 : 1'b0, (m_ph[i] == 2) ? 1'b1 : 1'b0, rdy});
    endfunction

    task automatic model_step(input int i);
        int a;
        m_we[i] = 0;
        if (scu_begin) begin
            m_cur[i] = m_org[i]; m_base[i] = m_org[i]; m_rem[i] = int'(wb_len);
            m_ph[i] = (wb_len == 0) ? 2 : 1;
        end else if (m_ph[i] == 1) begin
            if (wr_valid && !stall) begin
                if (is_drc == 3'b001) begin
                    a = (m_base[i] + 8) % 32;
                    m_base[i] = a;
                end else begin
                    a = m_cur[i];
                end
                m_cur[i] = (a + 1) % 32;
                m_we[i] = 1; m_wa[i] = a;
                m_rem[i] = m_rem[i] - 1;
                if (m_rem[i] == 0) m_ph[i] = 2;
            end
        end else if (m_ph[i] == 2) begin
            m_ph[i] = 0;
        end
    endtask

    initial begin
        int q[$];
        int dones;
        int exp_abort[6] = '{0, 0, 1, 2, 3, 4};
        int exp_wrap[4]  = '{30, 31, 0, 1};
        int exp_rst[2]   = '{0, 1};

        tbl[0]  = {1'b1, 5'd4, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = {1'b0, 5'd0, 1'b1, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1};
        tbl[2]  = {1'b0, 5'd0, 1'b1, 3'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1};
        tbl[3]  = {1'b0, 5'd0, 1'b1, 3'd0, 1'b0, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1};
        tbl[4]  = {1'b0, 5'd0, 1'b1, 3'd0, 1'b0, 1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = {1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = {1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = {1'b1, 5'd3, 1'b0, 3'd0, 1'b0, 1'b0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = {1'b0, 5'd0, 1'b1, 3'd0, 1'b0, 1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1};
        tbl[9]  = {1'b0, 5'd0, 1'b1, 3'd1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1};
        tbl[10] = {1'b0, 5'd0, 1'b1, 3'd0, 1'b0, 1'b1, 5'd8, 5'd8, 1'b1, 1'b0, 1'b1};
        tbl[11] = {1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd9, 5'd8, 1'b0, 1'b1, 1'b0};
        tbl[12] = {1'b1, 5'd2, 1'b0, 3'd0, 1'b0, 1'b0, 5'd9, 5'd8, 1'b0, 1'b0, 1'b0};
        tbl[13] = {1'b0, 5'd0, 1'b1, 3'd3, 1'b0, 1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1};
        tbl[14] = {1'b0, 5'd0, 1'b1, 3'd4, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1};
        tbl[15] = {1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b0};
        tbl[16] = {1'b1, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0};
        tbl[17] = {1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd1, 5'd0, 1'b0, 1'b1, 1'b0};
        tbl[18] = {1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        scu_begin = 1'b0; wb_len = '0; wr_valid = 1'b0; is_drc = '0; stall = 1'b0;
        repeat (2) @(negedge sys_clk);
        #1;
        chk("reset_dut0", pack0(), int'({1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0}));
        chk("reset_dut1", pack1(), int'({1'b0, 5'd30, 5'd30, 1'b0, 1'b0, 1'b0}));
        @(negedge sys_clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].beg, tbl[i].len, tbl[i].vld, tbl[i].drc, tbl[i].stl);
            chk($sformatf("vec%0d", i), pack0(),
                int'({tbl[i].en, tbl[i].addr, tbl[i].base, tbl[i].busy, tbl[i].done, tbl[i].rdy}));
        end

        // Back-pressure across the address wrap on the base-30 instance.
        drive(1'b1, 5'd4, 1'b0, 3'd0, 1'b0);
        q.delete(); dones = 0;
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 5'd0, 1'b1, 3'd0, (k == 1));
            if (k == 0) chk("wrap_ready_free", int'(rdy1), 1);
            if (k == 1) chk("wrap_ready_stall", int'(rdy1), 0);
            if (en1) q.push_back(int'(addr1));
            if (done1) dones++;
        end
        chk("wrap_nwrites", q.size(), 4);
        for (int k = 0; k < 4 && k < q.size(); k++)
            chk($sformatf("wrap_addr%0d", k), q[k], exp_wrap[k]);
        chk("wrap_dones", dones, 1);

        // Restart during beat 2 of 5: that beat is dropped, no done for period 1.
        drive(1'b1, 5'd5, 1'b0, 3'd0, 1'b0);
        q.delete(); dones = 0;
        drive(1'b0, 5'd0, 1'b1, 3'd0, 1'b0);
        drive(1'b1, 5'd5, 1'b1, 3'd0, 1'b0);
        if (en0) q.push_back(int'(addr0));
        for (int k = 0; k < 12; k++) begin
            drive(1'b0, 5'd0, 1'b1, 3'd0, 1'b0);
            if (en0) q.push_back(int'(addr0));
            if (done0) dones++;
        end
        chk("abort_nwrites", q.size(), 6);
        for (int k = 0; k < 6 && k < q.size(); k++)
            chk($sformatf("abort_addr%0d", k), q[k], exp_abort[k]);
        chk("abort_dones", dones, 1);

        // Asynchronous reset between edges with a write in flight.
        drive(1'b1, 5'd8, 1'b0, 3'd0, 1'b0);
        drive(1'b0, 5'd0, 1'b1, 3'd1, 1'b0);
        drive(1'b0, 5'd0, 1'b1, 3'd0, 1'b0);
        chk("pre_rst_base", int'(base0), 8);
        @(posedge sys_clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_dut0", pack0(), int'({1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0}));
        @(negedge sys_clk);
        rst = 1'b0;
        drive(1'b1, 5'd2, 1'b0, 3'd0, 1'b0);
        q.delete(); dones = 0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 5'd0, 1'b1, 3'd0, 1'b0);
            if (en0) q.push_back(int'(addr0));
            if (done0) dones++;
        end
        chk("post_rst_nwrites", q.size(), 2);
        for (int k = 0; k < 2 && k < q.size(); k++)
            chk($sformatf("post_rst_addr%0d", k), q[k], exp_rst[k]);
        chk("post_rst_dones", dones, 1);

        // Random traffic against the model, both instances.
        @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 500; c++) begin
            logic [2:0] d;
            case ($urandom_range(0, 3))
                0: d = 3'b001;
                1: d = 3'b000;
                default: d = 3'($urandom_range(0, 7));
            endcase
            drive(($urandom_range(0, 15) == 0), 5'($urandom_range(0, 12)),
                  ($urandom_range(0, 3) != 0), d, ($urandom_range(0, 3) == 0));
            chk($sformatf("rand%0d_dut0", c), pack0(), model_exp(0));
            chk($sformatf("rand%0d_dut1", c), pack1(), model_exp(1));
            model_step(0);
            model_step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memshare_wraddr_ctrl.md
# memShare_wrAddr_ctrl

Write-side counterpart of the memShare request-address path. During the SCU.memShare() write-back period it accepts result beats from the SCU over a valid/ready handshake and generates the registered write-enable and write address into the message-passing buffer. A beat flagged with an exclusive DRC1 condition is written at a rebased address. The block tracks the remaining beat count and signals completion.

## Interface
- ADDR_WIDTH, 5, message-passing buffer address width; addresses wrap modulo 2^ADDR_WIDTH.
- LEN_WIDTH, 5, width of the beat-count input.
- DRC_NUM, 3, number of DRC flags; bit 0 = DRC1, bit 1 = DRC2, bit 2 = DRC3.
- ADDR_BASE, 0, start address and DRC base loaded at each period start.
- REBASE_STRIDE, 8, offset added to the DRC base on every DRC1 rebase.
- sys_clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- scu_begin_i  in  1  single-cycle pulse that starts or restarts a write-back period.
- wb_len_i  in  LEN_WIDTH  number of beats in the period; sampled with scu_begin_i.
- wr_valid_i  in  1  SCU presents a result beat.
- is_drc_i  in  DRC_NUM  DRC flags of the presented beat; qualified by wr_valid_i.
- stall_i  in  1  buffer write port is busy (port conflict).
- wr_ready_o  out  1  block accepts a beat this cycle.
- wr_en_o  out  1  buffer write enable.
- wr_addr_o  out  ADDR_WIDTH  buffer write address.
- drc_base_addr_o  out  ADDR_WIDTH  current DRC base.
- busy_o  out  1  high in the WRITE state.
- done_o  out  1  single-cycle pulse when the period completes.

## Operation
- States: IDLE, WRITE, DONE.
- IDLE, on scu_begin_i:
  - Load cur_addr and drc_base with ADDR_BASE.
  - Load remaining count with wb_len_i.
  - Go to DONE if wb_len_i == 0; otherwise go to WRITE.
- WRITE:
  - wr_ready_o = !stall_i. This is combinational from stall_i and state.
  - A beat is accepted when wr_valid_i && wr_ready_o.
- Exclusive DRC1 means is_drc_i == 3'b001. Only this condition rebases.
- On an accepted beat with exclusive DRC1:
  - Write address A = drc_base + REBASE_STRIDE.
  - drc_base <= A.
  - cur_addr <= A + 1.
- On any other accepted beat:
  - A = cur_addr.
  - cur_addr <= cur_addr + 1.
  - drc_base is unchanged.
- All additions are truncated to ADDR_WIDTH and wrap silently.
- On every accepted beat the remaining count decrements. Accepting the beat with count == 1 moves the FSM to DONE.
- DONE lasts one cycle:
  - done_o = 1.
  - Go to IDLE.
  - If scu_begin_i is also high, restart as from IDLE instead; done_o is still asserted.
- scu_begin_i in WRITE aborts the period and reloads as from IDLE.
  - It has priority over a beat accepted in the same cycle. That beat is dropped: no wr_en_o.
  - done_o is not pulsed for the aborted period.
- wr_valid_i outside WRITE is ignored.

## Timing
- Reset values:
  - FSM in IDLE.
  - wr_en_o = 0, wr_addr_o = ADDR_BASE, drc_base_addr_o = ADDR_BASE.
  - busy_o = 0, done_o = 0, wr_ready_o = 0.
- Write latency is 1 cycle. A beat accepted in cycle t gives wr_en_o = 1 and wr_addr_o = A in cycle t+1. wr_en_o is 0 in cycle t+1 otherwise.
- wr_addr_o holds its last value when wr_en_o = 0.
- drc_base_addr_o is registered. It reflects the rebase in cycle t+1, together with the write.
- Throughput is one beat per cycle while stall_i = 0.
- stall_i deasserts wr_ready_o in the same cycle. No beat is lost; the SCU holds wr_valid_i.
- done_o rises the cycle after the last beat is accepted, coincident with the last wr_en_o.
- busy_o is registered state decode: high exactly while in WRITE.
- Asserting rst mid-period immediately returns all outputs to their reset values. Any pending write is discarded.

## Test plan
- Plain run: scu_begin_i, wb_len_i = 4, DRC flags 0, continuous valid -> wr_en_o for 4 cycles at addresses 0, 1, 2, 3; done_o with the 4th write; busy_o low afterwards.
- Rebase: wb_len_i = 3, beat 2 with is_drc_i = 3'b001 -> addresses 0, 8, 9; drc_base_addr_o = 8 from the 2nd write on.
- Non-exclusive DRC: beat with is_drc_i = 3'b011 or 3'b100 -> no rebase; sequential address; drc_base_addr_o unchanged.
- Back-pressure plus wrap: ADDR_BASE = 30, wb_len_i = 4, stall_i high in cycle 2 -> wr_ready_o low that cycle; addresses 30, 31, 0, 1 with no loss or duplicate.
- Abort/zero length: scu_begin_i during beat 2 of 5 -> beat dropped, restart at ADDR_BASE, no done_o for the first period. wb_len_i = 0 -> done_o one cycle after start, no writes.
- Async reset: rst asserted mid-WRITE between clock edges -> outputs at reset values immediately; a new scu_begin_i after release runs normally.
